// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: select-width helper
// and the update-source priority encoding used inside each register cell.
package regfile_pkg;

    function automatic int sel_width(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_ALU  = 3'd1,
        SRC_DATA = 3'd2,
        SRC_ADDR = 3'd3,
        SRC_STEP = 3'd4
    } src_e;

endpackage

// File: rtl/regfile_cell.sv
// One register of the file: priority-resolved update from ALU, data bus,
// address bus or inc/dec, plus a local same-cycle conflict indication.
module regfile_cell
    import regfile_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_hit,
    input  logic             data_hit,
    input  logic             addr_hit,
    input  logic             inc_hit,
    input  logic             dec_hit,
    input  logic [WIDTH-1:0] alu_val,
    input  logic [WIDTH-1:0] data_val,
    input  logic [WIDTH-1:0] addr_val,
    output logic [WIDTH-1:0] q,
    output logic             conflict
);

    src_e src;
    logic step_hit;

    assign step_hit = inc_hit || dec_hit;

    always_comb begin
        src = SRC_NONE;
        if (alu_hit)
            src = SRC_ALU;
        else if (data_hit)
            src = SRC_DATA;
        else if (addr_hit)
            src = SRC_ADDR;
        else if (step_hit)
            src = SRC_STEP;
    end

    // inc and dec together count as two sources fighting over the register
    always_comb begin
        conflict = (alu_hit  && (data_hit || addr_hit || step_hit)) ||
                   (data_hit && (addr_hit || step_hit)) ||
                   (addr_hit && step_hit) ||
                   (inc_hit  && dec_hit);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            case (src)
                SRC_ALU:  q <= alu_val;
                SRC_DATA: q <= data_val;
                SRC_ADDR: q <= addr_val;
                SRC_STEP: begin
                    if (inc_hit && !dec_hit)
                        q <= q + WIDTH'(1);
                    else if (dec_hit && !inc_hit)
                        q <= q - WIDTH'(1);
                end
                default:  q <= q;
            endcase
        end
    end

endmodule

// File: rtl/regfile_multi.sv
// Multi-port register file with tri-state read buses and a sticky conflict flag.
// Optional REGFILE_BYPASS_EN forwards same-cycle data/address writes to the ALU operand buses.
module regfile_multi
    import regfile_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 4,
    localparam int SELW  = sel_width(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdata,
    input  logic [SELW-1:0]  rdata_sel,
    output logic [WIDTH-1:0] out_data,
    input  logic             raddr,
    input  logic [SELW-1:0]  raddr_sel,
    output logic [WIDTH-1:0] out_addr,
    input  logic             alu_r_a,
    input  logic [SELW-1:0]  alu_a_sel,
    output logic [WIDTH-1:0] alu_a_bus,
    input  logic             alu_r_b,
    input  logic [SELW-1:0]  alu_b_sel,
    output logic [WIDTH-1:0] alu_b_bus,
    input  logic             wdata,
    input  logic [SELW-1:0]  wdata_sel,
    input  logic [WIDTH-1:0] in_data,
    input  logic             waddr,
    input  logic [SELW-1:0]  waddr_sel,
    input  logic [WIDTH-1:0] in_addr,
    input  logic             alu_w,
    input  logic [SELW-1:0]  alu_w_sel,
    input  logic [WIDTH-1:0] alu_out_bus,
    input  logic             inc,
    input  logic             dec,
    input  logic [SELW-1:0]  step_sel,
    output logic             wr_conflict
);

    localparam int NSLOTS = 2 ** SELW;

    logic [WIDTH-1:0] regs [NSLOTS];
    logic [NSLOTS-1:0] cell_conflict;
    logic [WIDTH-1:0] alu_a_val;
    logic [WIDTH-1:0] alu_b_val;

    // Unused select codes are padded with zero so out-of-range reads return 0
    for (genvar i = 0; i < NSLOTS; i++) begin : g_reg
        if (i < NREGS) begin : g_cell
            regfile_cell #(.WIDTH(WIDTH)) u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .alu_hit  (alu_w && (alu_w_sel == SELW'(i))),
                .data_hit (wdata && (wdata_sel == SELW'(i))),
                .addr_hit (waddr && (waddr_sel == SELW'(i))),
                .inc_hit  (inc   && (step_sel  == SELW'(i))),
                .dec_hit  (dec   && (step_sel  == SELW'(i))),
                .alu_val  (alu_out_bus),
                .data_val (in_data),
                .addr_val (in_addr),
                .q        (regs[i]),
                .conflict (cell_conflict[i])
            );
        end else begin : g_pad
            assign regs[i]          = '0;
            assign cell_conflict[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            wr_conflict <= 1'b0;
        else if (|cell_conflict)
            wr_conflict <= 1'b1;
    end

    function automatic logic [WIDTH-1:0] operand(input logic [SELW-1:0] sel);
        logic [WIDTH-1:0] val;
        val = regs[sel];
`ifdef REGFILE_BYPASS_EN
        // ALU writes are never forwarded, otherwise the ALU would loop on itself
        if ((int'(sel) < NREGS) && !(alu_w && (alu_w_sel == sel))) begin
            if (wdata && (wdata_sel == sel))
                val = in_data;
            else if (waddr && (waddr_sel == sel))
                val = in_addr;
        end
`endif
        return val;
    endfunction

    always_comb begin
        alu_a_val = operand(alu_a_sel);
        alu_b_val = operand(alu_b_sel);
    end

    assign out_data  = rdata   ? regs[rdata_sel] : {WIDTH{1'bz}};
    assign out_addr  = raddr   ? regs[raddr_sel] : {WIDTH{1'bz}};
    assign alu_a_bus = alu_r_a ? alu_a_val       : {WIDTH{1'bz}};
    assign alu_b_bus = alu_r_b ? alu_b_val       : {WIDTH{1'bz}};

endmodule

// File: tb/tb_regfile_multi.sv
// Directed testbench for regfile_multi: a 4-register and a 3-register instance
// share stimulus; the 3-register copy covers out-of-range selects.
module tb_regfile_multi;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rdata, raddr, alu_r_a, alu_r_b;
    logic [1:0]   rdata_sel, raddr_sel, alu_a_sel, alu_b_sel;
    logic         wdata, waddr, alu_w, inc, dec;
    logic [1:0]   wdata_sel, waddr_sel, alu_w_sel, step_sel;
    logic [W-1:0] in_data, in_addr, alu_out_bus;

    logic [W-1:0] out_data, out_addr, alu_a_bus, alu_b_bus;
    logic         wr_conflict;
    logic [W-1:0] out_data3, out_addr3, alu_a_bus3, alu_b_bus3;
    logic         wr_conflict3;

    int vec_count  = 0;
    int miss_count = 0;

    always #5 clk = ~clk;

    regfile_multi #(.WIDTH(W), .NREGS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rdata(rdata), .rdata_sel(rdata_sel), .out_data(out_data),
        .raddr(raddr), .raddr_sel(raddr_sel), .out_addr(out_addr),
        .alu_r_a(alu_r_a), .alu_a_sel(alu_a_sel), .alu_a_bus(alu_a_bus),
        .alu_r_b(alu_r_b), .alu_b_sel(alu_b_sel), .alu_b_bus(alu_b_bus),
        .wdata(wdata), .wdata_sel(wdata_sel), .in_data(in_data),
        .waddr(waddr), .waddr_sel(waddr_sel), .in_addr(in_addr),
        .alu_w(alu_w), .alu_w_sel(alu_w_sel), .alu_out_bus(alu_out_bus),
        .inc(inc), .dec(dec), .step_sel(step_sel),
        .wr_conflict(wr_conflict)
    );

    regfile_multi #(.WIDTH(W), .NREGS(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .rdata(rdata), .rdata_sel(rdata_sel), .out_data(out_data3),
        .raddr(raddr), .raddr_sel(raddr_sel), .out_addr(out_addr3),
        .alu_r_a(alu_r_a), .alu_a_sel(alu_a_sel), .alu_a_bus(alu_a_bus3),
        .alu_r_b(alu_r_b), .alu_b_sel(alu_b_sel), .alu_b_bus(alu_b_bus3),
        .wdata(wdata), .wdata_sel(wdata_sel), .in_data(in_data),
        .waddr(waddr), .waddr_sel(waddr_sel), .in_addr(in_addr),
        .alu_w(alu_w), .alu_w_sel(alu_w_sel), .alu_out_bus(alu_out_bus),
        .inc(inc), .dec(dec), .step_sel(step_sel),
        .wr_conflict(wr_conflict3)
    );

    task automatic checkOutput(input string tag, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic clearEnables();
        rdata = 0; raddr = 0; alu_r_a = 0; alu_r_b = 0;
        wdata = 0; waddr = 0; alu_w = 0; inc = 0; dec = 0;
    endtask

    // Advance one clock, leaving inputs stable until 1 time unit after the edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        clearEnables();
        rst_n = 0;
        applyStimulus();
        rst_n = 1;
    endtask

    task automatic readAll(input logic [1:0] s_d, input logic [1:0] s_a,
                           input logic [1:0] s_ra, input logic [1:0] s_rb);
        rdata = 1; raddr = 1; alu_r_a = 1; alu_r_b = 1;
        rdata_sel = s_d; raddr_sel = s_a; alu_a_sel = s_ra; alu_b_sel = s_rb;
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1;
        rdata_sel = 0; raddr_sel = 0; alu_a_sel = 0; alu_b_sel = 0;
        wdata_sel = 0; waddr_sel = 0; alu_w_sel = 0; step_sel = 0;
        in_data = 0; in_addr = 0; alu_out_bus = 0;
        clearEnables();
        doReset();

        // Preload every register with 5A using three ports at once, then r3
        alu_w = 1; alu_w_sel = 0; alu_out_bus = 8'h5A;
        wdata = 1; wdata_sel = 1; in_data = 8'h5A;
        waddr = 1; waddr_sel = 2; in_addr = 8'h5A;
        applyStimulus();
        clearEnables();
        wdata = 1; wdata_sel = 3; in_data = 8'h5A;
        applyStimulus();
        clearEnables();
        rdata_sel = 2;
        #1;
        checkOutput("disabled_bus_not_driven", out_data === 8'h5A ? 8'h01 : 8'h00, 8'h00);
        readAll(0, 1, 2, 3);
        checkOutput("preload_r0", out_data, 8'h5A);
        checkOutput("preload_r3", alu_b_bus, 8'h5A);

        // Reset overrides a simultaneous write; old value visible until the edge
        rst_n = 0; wdata = 1; wdata_sel = 1; in_data = 8'h99;
        #1;
        checkOutput("pre_reset_edge_r1", out_addr, 8'h5A);
        applyStimulus();
        rst_n = 1; wdata = 0;
        #1;
        checkOutput("reset_r0", out_data, 8'h00);
        checkOutput("reset_r1", out_addr, 8'h00);
        checkOutput("reset_r2", alu_a_bus, 8'h00);
        checkOutput("reset_r3", alu_b_bus, 8'h00);
        checkOutput("reset_conflict", {7'b0, wr_conflict}, 8'h00);

        // Out-of-range writes on the 3-register instance are ignored
        clearEnables();
        wdata = 1; wdata_sel = 3; in_data = 8'hAA;
        waddr = 1; waddr_sel = 3; in_addr = 8'h55;
        applyStimulus();
        clearEnables();
        readAll(3, 0, 1, 2);
        checkOutput("oor_read_zero", out_data3, 8'h00);
        checkOutput("oor_r0_kept", out_addr3, 8'h00);
        checkOutput("oor_r1_kept", alu_a_bus3, 8'h00);
        checkOutput("oor_r2_kept", alu_b_bus3, 8'h00);
        checkOutput("oor_no_conflict", {7'b0, wr_conflict3}, 8'h00);
        checkOutput("inrange_conflict_r3", {7'b0, wr_conflict}, 8'h01);
        doReset();

        // Basic write, read-after-write latency on the operand bus
        clearEnables();
        wdata = 1; wdata_sel = 1; in_data = 8'h3C;
        alu_r_a = 1; alu_a_sel = 1;
        #1;
`ifdef REGFILE_BYPASS_EN
        checkOutput("same_cycle_r1", alu_a_bus, 8'h3C);
`else
        checkOutput("same_cycle_r1", alu_a_bus, 8'h00);
`endif
        applyStimulus();
        clearEnables();
        readAll(1, 1, 1, 1);
        checkOutput("write_r1_data", out_data, 8'h3C);
        checkOutput("write_r1_addr", out_addr, 8'h3C);
        checkOutput("write_r1_a", alu_a_bus, 8'h3C);
        checkOutput("write_r1_b", alu_b_bus, 8'h3C);

        // Priority: ALU beats data bus on r2; address bus lands on r3
        clearEnables();
        alu_w = 1; alu_w_sel = 2; alu_out_bus = 8'h11;
        wdata = 1; wdata_sel = 2; in_data = 8'h22;
        waddr = 1; waddr_sel = 3; in_addr = 8'h33;
        alu_r_a = 1; alu_a_sel = 2;
        #1;
        checkOutput("alu_write_not_bypassed", alu_a_bus, 8'h00);
        applyStimulus();
        clearEnables();
        readAll(2, 3, 2, 3);
        checkOutput("prio_r2", out_data, 8'h11);
        checkOutput("prio_r3", out_addr, 8'h33);
        checkOutput("prio_conflict", {7'b0, wr_conflict}, 8'h01);
        for (int i = 0; i < 10; i++) applyStimulus();
        checkOutput("conflict_sticky", {7'b0, wr_conflict}, 8'h01);
        checkOutput("idle_hold_r2", alu_a_bus, 8'h11);
        doReset();

        // Increment / decrement wrap-around
        clearEnables();
        wdata = 1; wdata_sel = 0; in_data = 8'hFF;
        applyStimulus();
        clearEnables();
        inc = 1; step_sel = 0;
        applyStimulus();
        clearEnables();
        readAll(0, 0, 0, 0);
        checkOutput("inc_wrap", out_data, 8'h00);
        dec = 1; step_sel = 0;
        applyStimulus();
        checkOutput("dec_wrap", out_data, 8'hFF);
        applyStimulus();
        dec = 0;
        #1;
        checkOutput("dec_twice", out_data, 8'hFE);
        checkOutput("step_no_conflict", {7'b0, wr_conflict}, 8'h00);
        inc = 1; dec = 1;
        applyStimulus();
        inc = 0; dec = 0;
        #1;
        checkOutput("inc_dec_hold", out_data, 8'hFE);
        checkOutput("inc_dec_conflict", {7'b0, wr_conflict}, 8'h01);
        doReset();

        // Forwarding of data/address writes, never of ALU writes
        clearEnables();
        wdata = 1; wdata_sel = 1; in_data = 8'h44;
        applyStimulus();
        clearEnables();
        wdata = 1; wdata_sel = 1; in_data = 8'h77;
        alu_r_a = 1; alu_a_sel = 1;
        alu_r_b = 1; alu_b_sel = 2;
        waddr = 1; waddr_sel = 2; in_addr = 8'h66;
        #1;
`ifdef REGFILE_BYPASS_EN
        checkOutput("bypass_wdata", alu_a_bus, 8'h77);
        checkOutput("bypass_waddr", alu_b_bus, 8'h66);
`else
        checkOutput("bypass_wdata", alu_a_bus, 8'h44);
        checkOutput("bypass_waddr", alu_b_bus, 8'h00);
`endif
        applyStimulus();
        wdata = 0; waddr = 0;
        alu_w = 1; alu_w_sel = 1; alu_out_bus = 8'h99;
        waddr = 1; waddr_sel = 1; in_addr = 8'h66;
        #1;
        checkOutput("alu_over_waddr_no_bypass", alu_a_bus, 8'h77);
        applyStimulus();
        clearEnables();
        readAll(1, 2, 1, 1);
        checkOutput("alu_commit_r1", out_data, 8'h99);
        checkOutput("waddr_commit_r2", out_addr, 8'h66);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
